// File: rtl/cpu_pkg.sv
// Shared CPU definitions: CP0 exception codes, Status bit positions and the
// exception scheduler state type.
package cpu_pkg;

    localparam logic [7:0] EXC_INT  = 8'h00;
    localparam logic [7:0] EXC_SYS  = 8'h08;
    localparam logic [7:0] EXC_BP   = 8'h09;
    localparam logic [7:0] EXC_RI   = 8'h0a;
    localparam logic [7:0] EXC_OV   = 8'h0c;
    localparam logic [7:0] EXC_TR   = 8'h0d;
    localparam logic [7:0] EXC_ERET = 8'h20;
    localparam logic [7:0] EXC_NONE = 8'hff;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

endpackage

// File: rtl/exc_sched_int_pend.sv
// Interrupt edge detection and sticky pending register. Bit 7 is the timer,
// bits [NUM_EXT-1:0] are the external lines; IM lines up bit-for-bit.
module int_pend
    import cpu_pkg::*;
#(
    parameter int NUM_EXT = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timer_int,
    input  logic [NUM_EXT-1:0] ext_int,
    input  logic               ie,
    input  logic               exl,
    input  logic [7:0]         im,
    input  logic               clr,
    output logic [7:0]         int_pending,
    output logic               int_ok
);

    localparam logic [7:0] VALID_MASK = 8'h80 | 8'((1 << NUM_EXT) - 1);

    logic [7:0] lvl;
    logic [7:0] hist_q;
    logic [7:0] pend_q;

    always_comb begin
        lvl = '0;
        lvl[7] = timer_int;
        lvl[NUM_EXT-1:0] = ext_int;
    end

    // New rising edges are OR-ed in after the clear so a set wins the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            pend_q <= '0;
        end else begin
            hist_q <= lvl;
            pend_q <= ((pend_q & ~(clr ? im : 8'h00)) | (lvl & ~hist_q)) & VALID_MASK;
        end
    end

    assign int_pending = pend_q;
    assign int_ok      = ie & ~exl & (|(pend_q & im));

endmodule

// File: rtl/exc_sched.sv
// Exception/interrupt scheduler: fixed-priority winner select, single-cycle
// CP0 strobe, then pipeline flush and a ready/valid PC redirect.
//   state    | meaning
//   IDLE     | waiting for a request or an enabled pending interrupt
//   COMMIT   | one-cycle exc_type/exc_pc strobe to CP0, first flush cycle
//   FLUSH    | flush held for the remaining FLUSH_CYCLES-1 cycles
//   REDIRECT | new pc offered until fetch accepts it
module exc_sched
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          NUM_EXT      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [31:0]        req_pc,
    input  logic               req_ri,
    input  logic               req_syscall,
    input  logic               req_break,
    input  logic               req_trap,
    input  logic               req_ov,
    input  logic               req_eret,
    input  logic               timer_int,
    input  logic [NUM_EXT-1:0] ext_int,
    input  logic [31:0]        status,
    input  logic [31:0]        epc,
    output logic [7:0]         exc_type,
    output logic [31:0]        exc_pc,
    output logic               stall,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    input  logic               redirect_ready,
    output logic [7:0]         int_pending
);

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

    state_t      state_q, state_d;
    logic [7:0]  code_q;
    logic [31:0] pc_q;
    logic [31:0] last_pc_q;
    logic [31:0] rpc_q;
    logic [3:0]  cnt_q;
    logic [7:0]  win_code;
    logic [31:0] win_pc;
    logic        int_ok;
    logic        int_clr;
    logic        unused_status;

    assign unused_status = ^{status[31:16], status[7:2]};

    int_pend #(.NUM_EXT(NUM_EXT)) u_int_pend (
        .clk         (clk),
        .rst         (rst),
        .timer_int   (timer_int),
        .ext_int     (ext_int),
        .ie          (status[STATUS_IE]),
        .exl         (status[STATUS_EXL]),
        .im          (status[STATUS_IM_HI:STATUS_IM_LO]),
        .clr         (int_clr),
        .int_pending (int_pending),
        .int_ok      (int_ok)
    );

    always_comb begin
        win_code = EXC_NONE;
        win_pc   = req_valid ? req_pc : last_pc_q;
        if      (req_valid && req_ri)      win_code = EXC_RI;
        else if (req_valid && req_syscall) win_code = EXC_SYS;
        else if (req_valid && req_break)   win_code = EXC_BP;
        else if (req_valid && req_trap)    win_code = EXC_TR;
        else if (req_valid && req_ov)      win_code = EXC_OV;
        else if (req_valid && req_eret)    win_code = EXC_ERET;
        else if (int_ok)                   win_code = EXC_INT;
    end

    always_comb begin
        state_d        = state_q;
        exc_type       = EXC_NONE;
        exc_pc         = '0;
        stall          = 1'b1;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        int_clr        = 1'b0;
        case (state_q)
            IDLE: begin
                stall = 1'b0;
                if (win_code != EXC_NONE) state_d = COMMIT;
            end
            COMMIT: begin
                exc_type = code_q;
                exc_pc   = pc_q;
                flush    = 1'b1;
                int_clr  = (code_q == EXC_INT);
                state_d  = (FLUSH_CYCLES > 1) ? FLUSH : REDIRECT;
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt_q == 4'd0) state_d = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = rpc_q;
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= EXC_NONE;
            pc_q      <= '0;
            last_pc_q <= '0;
            rpc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (req_valid) last_pc_q <= req_pc;
                if (win_code != EXC_NONE) begin
                    code_q <= win_code;
                    pc_q   <= win_pc;
                end
            end
            if (state_q == COMMIT)
                cnt_q <= CNT_LOAD;
            else if (state_q == FLUSH && cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
            // Redirect target is captured once on entry and held until accepted.
            if (state_d == REDIRECT && state_q != REDIRECT)
                rpc_q <= (code_q == EXC_ERET) ? epc : EXC_VECTOR;
        end
    end

endmodule
